// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the RV32I register file slice.
// Imported by the decoder and the register file top.
package regfile_scoreboard_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN       = 32;
   localparam int X0_IDX     = 0;

   function automatic logic [5:0] popcnt(input logic [NUM_REGS-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < NUM_REGS; i++)
         c = c + 6'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/regfile_scoreboard_dec.sv
// 5-to-32 load-enable decoder: one-hot output when load_enable is high.
// Shared codebase block, also used for the scoreboard set vector.
module DECODER5to32
   import regfile_scoreboard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] D_addr,
   input  logic                  load_enable,
   output logic [NUM_REGS-1:0]   dec_o
);

   always_comb begin
      dec_o = '0;
      if (load_enable)
         dec_o[D_addr] = 1'b1;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// RV32I register file with write-first bypass and a pending-write
// scoreboard that flags long-latency destinations for decode stalls.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int                DATA_W    = XLEN,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0]     rs1_data,
   output logic [DATA_W-1:0]     rs2_data,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_long,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic [5:0]            busy_cnt
);

   logic [NUM_REGS-1:0] we;
   logic [NUM_REGS-1:0] set_v;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];

   DECODER5to32 u_wr_dec (
      .D_addr      (wr_addr),
      .load_enable (wr_en),
      .dec_o       (we)
   );

   DECODER5to32 u_set_dec (
      .D_addr      (issue_rd),
      .load_enable (issue_valid & issue_long),
      .dec_o       (set_v)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k < NUM_REGS; k++)
            regs_q[k] <= RESET_VAL;
      end else begin
         for (int k = 1; k < NUM_REGS; k++)
            if (we[k])
               regs_q[k] <= wr_data;
      end
   end

   // A new long writer issued in the same cycle as a writeback wins.
   always_comb begin
      busy_d         = (busy_q & ~we) | set_v;
      busy_d[X0_IDX] = 1'b0;
      cnt_d          = popcnt(busy_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      rs1_data = '0;
      if (rs1_addr != REG_ADDR_W'(X0_IDX)) begin
         if (wr_en && wr_addr == rs1_addr)
            rs1_data = wr_data;
         else
            rs1_data = regs_q[rs1_addr];
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != REG_ADDR_W'(X0_IDX)) begin
         if (wr_en && wr_addr == rs2_addr)
            rs2_data = wr_data;
         else
            rs2_data = regs_q[rs2_addr];
      end
   end

   assign rs1_busy = busy_q[rs1_addr] & ~(wr_en & (wr_addr == rs1_addr));
   assign rs2_busy = busy_q[rs2_addr] & ~(wr_en & (wr_addr == rs2_addr));
   assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized self-checking bench for regfile_scoreboard against
// an array-based architectural model of registers and pending writes.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_long;
   logic        rs1_busy, rs2_busy;
   logic [5:0]  busy_cnt;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_reg  [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_long  (issue_long),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .busy_cnt    (busy_cnt)
   );

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 32'h0;
         m_busy[i] = 1'b0;
      end
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (wr_en && wr_addr == a) return wr_data;
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      return m_busy[a] && !(wr_en && wr_addr == a);
   endfunction

   function automatic logic [5:0] exp_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return 6'(c);
   endfunction

   task automatic drive(input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic iv,
                        input logic [4:0] ird, input logic il,
                        input logic [4:0] r1, input logic [4:0] r2);
      wr_en = we; wr_addr = wa; wr_data = wd;
      issue_valid = iv; issue_rd = ird; issue_long = il;
      rs1_addr = r1; rs2_addr = r2;
      #1;
   endtask

   task automatic tick();
      if (wr_en) begin
         if (wr_addr != 5'd0) m_reg[wr_addr] = wr_data;
         m_busy[wr_addr] = 1'b0;
      end
      if (issue_valid && issue_long && issue_rd != 5'd0)
         m_busy[issue_rd] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (busy_cnt !== 6'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d exp=0", busy_cnt);
      end
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
         checks++;
         if (rs1_data !== 32'h0 || rs2_data !== 32'h0 ||
             rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_read idx=%0d got=%h/%h busy=%b%b exp=0",
                     i, rs1_data, rs2_data, rs1_busy, rs2_busy);
         end
      end
   endtask

   task automatic test_write_bypass();
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 1);
      checks++;
      if (rs1_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL bypass got=%h exp=deadbeef", rs1_data);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 5, 1);
      checks++;
      if (rs1_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL stored got=%h exp=deadbeef", rs1_data);
      end
   endtask

   task automatic test_x0();
      drive(1, 0, 32'h12345678, 0, 0, 0, 1, 0);
      checks++;
      if (rs2_data !== 32'h0) begin
         failures++;
         $display("FAIL x0_same got=%h exp=0", rs2_data);
      end
      tick();
      drive(0, 0, 0, 1, 0, 1, 1, 0);
      checks++;
      if (rs2_data !== 32'h0) begin
         failures++;
         $display("FAIL x0_after got=%h exp=0", rs2_data);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0) begin
         failures++;
         $display("FAIL x0_issue cnt=%0d busy=%b exp=0/0", busy_cnt, rs1_busy);
      end
   endtask

   task automatic test_long();
      drive(0, 0, 0, 1, 7, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      checks++;
      if (rs1_busy !== 1'b1 || busy_cnt !== 6'd1) begin
         failures++;
         $display("FAIL long_set busy=%b cnt=%0d exp=1/1", rs1_busy, busy_cnt);
      end
      drive(1, 7, 32'hA5, 0, 0, 0, 7, 0);
      checks++;
      if (rs1_busy !== 1'b0 || rs1_data !== 32'hA5) begin
         failures++;
         $display("FAIL long_wb busy=%b data=%h exp=0/a5", rs1_busy, rs1_data);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 7, 0);
      checks++;
      if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0) begin
         failures++;
         $display("FAIL long_clr cnt=%0d busy=%b exp=0/0", busy_cnt, rs1_busy);
      end
   endtask

   task automatic test_set_clr();
      drive(1, 9, 32'hCAFE0009, 1, 9, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 9, 9);
      checks++;
      if (busy_cnt !== 6'd1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
         failures++;
         $display("FAIL setclr_busy cnt=%0d busy=%b%b exp=1/11",
                  busy_cnt, rs1_busy, rs2_busy);
      end
      checks++;
      if (rs1_data !== 32'hCAFE0009) begin
         failures++;
         $display("FAIL setclr_data got=%h exp=cafe0009", rs1_data);
      end
      drive(1, 9, 32'hCAFE0109, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      logic [4:0] wa, ird, r1, r2;
      for (int n = 0; n < 400; n++) begin
         wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         ird = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r1  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         r2  = 5'($urandom);
         drive(1'($urandom_range(0, 2) == 0), wa, $urandom,
               1'($urandom_range(0, 1)), ird, 1'($urandom_range(0, 1)), r1, r2);
         checks++;
         if (rs1_data !== exp_read(r1) || rs2_data !== exp_read(r2)) begin
            failures++;
            $display("FAIL rand_read n=%0d got=%h/%h exp=%h/%h",
                     n, rs1_data, rs2_data, exp_read(r1), exp_read(r2));
         end
         checks++;
         if (rs1_busy !== exp_busy(r1) || rs2_busy !== exp_busy(r2)) begin
            failures++;
            $display("FAIL rand_busy n=%0d got=%b%b exp=%b%b",
                     n, rs1_busy, rs2_busy, exp_busy(r1), exp_busy(r2));
         end
         tick();
         checks++;
         if (busy_cnt !== exp_cnt()) begin
            failures++;
            $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, busy_cnt, exp_cnt());
         end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 0, 1, 5'(i), 1, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 31, 0);
      checks++;
      if (busy_cnt !== 6'd31 || busy_cnt !== exp_cnt()) begin
         failures++;
         $display("FAIL fill_cnt got=%0d exp=31", busy_cnt);
      end
   endtask

   task automatic test_reset_mid();
      drive(1, 3, 32'h33333333, 1, 3, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 4, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 31, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 3, 31);
      checks++;
      if (busy_cnt !== exp_cnt() || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_rst cnt=%0d busy=%b%b exp=%0d/11",
                  busy_cnt, rs1_busy, rs2_busy, exp_cnt());
      end
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_busy cnt=%0d busy=%b%b exp=0/00",
                  busy_cnt, rs1_busy, rs2_busy);
      end
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
         failures++;
         $display("FAIL mid_rst_data got=%h/%h exp=0", rs1_data, rs2_data);
      end
      #2;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 4, 9);
      tick();
      checks++;
      if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0 || rs2_data !== 32'h0) begin
         failures++;
         $display("FAIL post_rst cnt=%0d busy=%b x9=%h exp=0/0/0",
                  busy_cnt, rs1_busy, rs2_data);
      end
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_x0();
      test_long();
      test_set_clr();
      test_random();
      test_fill();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
